rs_int_issue_select: RTL and testbench

- Issue stage directly downstream of the integer reservation-station lines.
- Each cycle it scans the LINES station lines and picks one in READY state using round-robin priority.
- It pulses that line's issue enable and captures the line's payload into a one-entry output register.
- It presents the payload to the integer ALU with a valid/ready handshake, and supports flush.

---
 rtl/rs_int_issue_select_pkg.sv | 21 ++
 rtl/rs_int_issue_select_rr_pick_onehot.sv | 32 +++
 rtl/rs_int_issue_select.sv | 103 ++++++++++
 tb/tb_rs_int_issue_select.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_int_issue_select_pkg.sv
// Shared encodings and default widths for the integer reservation-station issue stage.
// Line state encodings must match the reservation-station lines that drive line_state.
package rs_int_issue_select_pkg;

  localparam int RS_LINES      = 4;
  localparam int RS_IDX_W      = 2;
  localparam int RS_ROB_ADDR_W = 4;
  localparam int RS_EXC_W      = 5;
  localparam int RS_OPGEN_W    = 6;
  localparam int RS_DATA_W     = 32;
  localparam int RS_STATE_W    = 3;

  typedef enum logic [RS_STATE_W-1:0] {
    RS_STATE_NONE   = 3'd0,
    RS_STATE_WRITE  = 3'd1,
    RS_STATE_READY  = 3'd2,
    RS_STATE_WAIT   = 3'd3,
    RS_STATE_COMMIT = 3'd4
  } rs_state_e;

endpackage

// File: rtl/rs_int_issue_select_rr_pick_onehot.sv
// Round-robin picker: first requester at or after ptr, searching upward with wrap.
// Purely combinational so it can be shared with the memory-RS issue stage.
module rr_pick_onehot #(
  parameter int LINES = 4,
  parameter int IDX_W = 2
) (
  input  logic [LINES-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [LINES-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] probe;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    probe = '0;
    for (int k = 0; k < LINES; k++) begin
      probe = ptr + IDX_W'(k);
      if (!any && req[probe]) begin
        any          = 1'b1;
        idx          = probe;
        grant[probe] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_int_issue_select.sv
// Integer RS issue select: round-robin pick of a READY line into a one-entry
// output register that feeds the ALU through a valid/ready handshake.
module rs_int_issue_select
  import rs_int_issue_select_pkg::*;
#(
  parameter int LINES      = RS_LINES,
  parameter int IDX_W      = RS_IDX_W,
  parameter int ROB_ADDR_W = RS_ROB_ADDR_W,
  parameter int EXC_W      = RS_EXC_W,
  parameter int OPGEN_W    = RS_OPGEN_W,
  parameter int DATA_W     = RS_DATA_W,
  parameter int STATE_W    = RS_STATE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [LINES*STATE_W-1:0]   line_state,
  input  logic [LINES*ROB_ADDR_W-1:0] line_rob_addr,
  input  logic [LINES*EXC_W-1:0]     line_exc_type,
  input  logic [LINES*OPGEN_W-1:0]   line_opgen,
  input  logic [LINES*DATA_W-1:0]    line_operand_1,
  input  logic [LINES*DATA_W-1:0]    line_operand_2,
  output logic [LINES-1:0]           line_issue_en,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [IDX_W-1:0]           alu_line_idx,
  output logic [ROB_ADDR_W-1:0]      alu_rob_addr,
  output logic [EXC_W-1:0]           alu_exc_type,
  output logic [OPGEN_W-1:0]         alu_opgen,
  output logic [DATA_W-1:0]          alu_operand_1,
  output logic [DATA_W-1:0]          alu_operand_2,
  output logic [15:0]                issue_count
);

  logic [LINES-1:0] cand;
  logic [LINES-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] ptr;
  logic             any_cand;
  logic             can_load;
  logic             fire;

  always_comb begin
    cand = '0;
    for (int i = 0; i < LINES; i++) begin
      cand[i] = (line_state[i*STATE_W +: STATE_W] == STATE_W'(RS_STATE_READY));
    end
  end

  rr_pick_onehot #(
    .LINES(LINES),
    .IDX_W(IDX_W)
  ) u_pick (
    .req  (cand),
    .ptr  (ptr),
    .grant(grant),
    .idx  (sel_idx),
    .any  (any_cand)
  );

  // The line leaves READY on the same edge, so this is a single-cycle pulse per op.
  assign can_load      = !alu_valid || alu_ready;
  assign fire          = any_cand && can_load && !flush && !rst;
  assign line_issue_en = fire ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the payload register is reset too, because downstream sees zeros after reset rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      alu_valid     <= 1'b0;
      alu_line_idx  <= '0;
      alu_rob_addr  <= '0;
      alu_exc_type  <= '0;
      alu_opgen     <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
    end else if (flush) begin
      alu_valid <= 1'b0;
    end else if (fire) begin
      ptr           <= sel_idx + IDX_W'(1);
      alu_valid     <= 1'b1;
      alu_line_idx  <= sel_idx;
      alu_rob_addr  <= line_rob_addr[sel_idx*ROB_ADDR_W +: ROB_ADDR_W];
      alu_exc_type  <= line_exc_type[sel_idx*EXC_W +: EXC_W];
      alu_opgen     <= line_opgen[sel_idx*OPGEN_W +: OPGEN_W];
      alu_operand_1 <= line_operand_1[sel_idx*DATA_W +: DATA_W];
      alu_operand_2 <= line_operand_2[sel_idx*DATA_W +: DATA_W];
    end else if (alu_ready) begin
      alu_valid <= 1'b0;
    end
  end

  // A handshake that coincides with flush is squashed and therefore not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
    end else if (alu_valid && alu_ready && !flush && (issue_count != 16'hFFFF)) begin
      issue_count <= issue_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rs_int_issue_select.sv
// Self-checking bench for rs_int_issue_select: per-cycle vector table with a
// payload scoreboard, plus hand-written reset, single-op and saturation sequences.
module tb_rs_int_issue_select;
  import rs_int_issue_select_pkg::*;

  localparam int LINES = 4, IDX_W = 2, ROB_ADDR_W = 4, EXC_W = 5, OPGEN_W = 6;
  localparam int DATA_W = 32, STATE_W = 3;
  localparam int NVEC = 20;

  logic                        clk = 1'b0;
  logic                        rst, flush, alu_ready;
  logic [LINES*STATE_W-1:0]    line_state;
  logic [LINES*ROB_ADDR_W-1:0] line_rob_addr;
  logic [LINES*EXC_W-1:0]      line_exc_type;
  logic [LINES*OPGEN_W-1:0]    line_opgen;
  logic [LINES*DATA_W-1:0]     line_operand_1, line_operand_2;
  logic [LINES-1:0]            line_issue_en;
  logic                        alu_valid;
  logic [IDX_W-1:0]            alu_line_idx;
  logic [ROB_ADDR_W-1:0]       alu_rob_addr;
  logic [EXC_W-1:0]            alu_exc_type;
  logic [OPGEN_W-1:0]          alu_opgen;
  logic [DATA_W-1:0]           alu_operand_1, alu_operand_2;
  logic [15:0]                 issue_count;

  rs_int_issue_select dut (
    .clk(clk), .rst(rst), .flush(flush),
    .line_state(line_state), .line_rob_addr(line_rob_addr),
    .line_exc_type(line_exc_type), .line_opgen(line_opgen),
    .line_operand_1(line_operand_1), .line_operand_2(line_operand_2),
    .line_issue_en(line_issue_en), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_line_idx(alu_line_idx), .alu_rob_addr(alu_rob_addr),
    .alu_exc_type(alu_exc_type), .alu_opgen(alu_opgen),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [ROB_ADDR_W-1:0] rob;
    logic [EXC_W-1:0]      exc;
    logic [OPGEN_W-1:0]    opgen;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
  } op_t;

  typedef struct {
    logic [LINES-1:0] ready;
    logic             ar;
    logic             fl;
    logic [LINES-1:0] exp_en;
    logic             exp_valid;
  } vec_t;

  vec_t vecs[NVEC];
  op_t  sb[$];
  op_t  exp_op;
  int   checks = 0;
  int   failures = 0;
  int   gen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(input int i, input int g);
    op_t o;
    o.idx   = IDX_W'(i);
    o.rob   = ROB_ADDR_W'(i + g);
    o.exc   = EXC_W'(3 * i + g);
    o.opgen = OPGEN_W'(i + 1 + g);
    o.op1   = {16'(g), 16'(i)};
    o.op2   = {16'(i * 7 + 1), 16'(g + 3)};
    return o;
  endfunction

  function automatic int onehot_idx(input logic [LINES-1:0] v);
    int r = 0;
    for (int i = 0; i < LINES; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Non-ready lines sit in WAIT so that only the READY encoding counts as a candidate.
  task automatic drive_lines(input logic [LINES-1:0] ready);
    op_t o;
    gen++;
    for (int i = 0; i < LINES; i++) begin
      o = mk_op(i, gen);
      line_state[i*STATE_W +: STATE_W]        = ready[i] ? STATE_W'(RS_STATE_READY) : STATE_W'(RS_STATE_WAIT);
      line_rob_addr[i*ROB_ADDR_W +: ROB_ADDR_W] = o.rob;
      line_exc_type[i*EXC_W +: EXC_W]         = o.exc;
      line_opgen[i*OPGEN_W +: OPGEN_W]        = o.opgen;
      line_operand_1[i*DATA_W +: DATA_W]      = o.op1;
      line_operand_2[i*DATA_W +: DATA_W]      = o.op2;
    end
  endtask

  task automatic drive_idle();
    line_state     = '0;
    line_rob_addr  = '0;
    line_exc_type  = '0;
    line_opgen     = '0;
    line_operand_1 = '0;
    line_operand_2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; alu_ready = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_payload(input string tag, input op_t e);
    check({tag, " meta"}, 64'({alu_line_idx, alu_rob_addr, alu_exc_type, alu_opgen}),
          64'({e.idx, e.rob, e.exc, e.opgen}));
    check({tag, " operands"}, {alu_operand_1, alu_operand_2}, {e.op1, e.op2});
  endtask

  initial begin
    // ready, alu_ready, flush, expected issue_en (pre-edge), expected alu_valid (pre-edge)
    vecs[0]  = '{4'b1011, 1'b1, 1'b0, 4'b0001, 1'b0};  // round robin 0,1,3,0,1,3
    vecs[1]  = '{4'b1011, 1'b1, 1'b0, 4'b0010, 1'b1};
    vecs[2]  = '{4'b1011, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[3]  = '{4'b1011, 1'b1, 1'b0, 4'b0001, 1'b1};
    vecs[4]  = '{4'b1011, 1'b1, 1'b0, 4'b0010, 1'b1};
    vecs[5]  = '{4'b1011, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0};  // backpressure
    vecs[9]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[11] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[12] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1};
    vecs[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[15] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0};  // flush while holding, pointer kept at 2
    vecs[16] = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1};
    vecs[17] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[18] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1};  // handshake squashed by flush
    vecs[19] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};

    // Reset with a READY line present: no pulse while rst is high.
    rst = 1'b1; flush = 1'b0; alu_ready = 1'b1;
    drive_lines(4'b0100);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst issue_en", 64'(line_issue_en), 64'h0);
    check("rst alu_valid", 64'(alu_valid), 64'h0);
    check("rst issue_count", 64'(issue_count), 64'h0);
    rst = 1'b0;
    drive_idle();

    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("idle%0d issue_en", c), 64'(line_issue_en), 64'h0);
      check($sformatf("idle%0d alu_valid", c), 64'(alu_valid), 64'h0);
      check($sformatf("idle%0d issue_count", c), 64'(issue_count), 64'h0);
    end

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      drive_lines(vecs[k].ready);
      alu_ready = vecs[k].ar;
      flush     = vecs[k].fl;
      #1;
      check($sformatf("v%0d issue_en", k), 64'(line_issue_en), 64'(vecs[k].exp_en));
      check($sformatf("v%0d alu_valid", k), 64'(alu_valid), 64'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        check($sformatf("v%0d scoreboard nonempty", k), 64'(sb.size() != 0), 64'h1);
        if (sb.size() != 0) begin
          check_payload($sformatf("v%0d", k), sb[0]);
          if (vecs[k].ar || vecs[k].fl) void'(sb.pop_front());
        end
      end
      if (vecs[k].exp_en != '0) sb.push_back(mk_op(onehot_idx(vecs[k].exp_en), gen));
    end
    check("table issue_count", 64'(issue_count), 64'd8);

    // Reset clears a previously loaded payload.
    do_reset();
    #1;
    check("reset alu_valid", 64'(alu_valid), 64'h0);
    check_payload("reset payload", '0);
    check("reset issue_count", 64'(issue_count), 64'h0);

    // Single op on line 2 with fixed payload; pointer then moves to 3.
    @(negedge clk);
    drive_idle();
    line_state[2*STATE_W +: STATE_W]          = STATE_W'(RS_STATE_READY);
    line_opgen[2*OPGEN_W +: OPGEN_W]          = 6'h03;
    line_operand_1[2*DATA_W +: DATA_W]        = 32'd5;
    line_operand_2[2*DATA_W +: DATA_W]        = 32'd7;
    line_rob_addr[2*ROB_ADDR_W +: ROB_ADDR_W] = 4'd9;
    alu_ready = 1'b1;
    #1;
    check("single issue_en", 64'(line_issue_en), 64'b0100);
    @(negedge clk);
    drive_idle();
    #1;
    check("single issue_en after", 64'(line_issue_en), 64'h0);
    check("single alu_valid", 64'(alu_valid), 64'h1);
    exp_op = '{idx: 2'd2, rob: 4'd9, exc: 5'd0, opgen: 6'h03, op1: 32'd5, op2: 32'd7};
    check_payload("single", exp_op);
    @(negedge clk);
    line_state[0*STATE_W +: STATE_W] = STATE_W'(RS_STATE_READY);
    line_state[3*STATE_W +: STATE_W] = STATE_W'(RS_STATE_READY);
    #1;
    check("pointer after 2 picks 3", 64'(line_issue_en), 64'b1000);
    check("single drained", 64'(alu_valid), 64'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check("single issue_count", 64'(issue_count), 64'd1);

    // Saturation: one line permanently READY, ALU always ready.
    do_reset();
    drive_lines(4'b0001);
    alu_ready = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk); #1;
    check("count 0xFFFE", 64'(issue_count), 64'hFFFE);
    @(posedge clk);
    @(negedge clk); #1;
    check("count 0xFFFF", 64'(issue_count), 64'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("count saturated", 64'(issue_count), 64'hFFFF);
    check("sat alu_valid", 64'(alu_valid), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
